fpio_serial_ctrl: RTL and testbench
===================================

// Module: fpio_serial_ctrl
// PURPOSE
//  Sequences the fpio byte FIFOs onto a single-wire serial link. Pops bytes from the host-to-ext
//  FIFO read side and shifts them out framed (start, 8 data LSB-first, stop); deserializes
//  incoming frames and pushes them into the ext-to-host FIFO write side. Bit rate set by divisor.
// PARAMETERS
//  FIFO_BITS   8   log2 FIFO depth; width of tx_avail is FIFO_BITS+1
//  DATA_WIDTH  8   bits per frame payload
// PORTS
//  clk          in   1             clock
//  rstn         in   1             synchronous active-low reset
//  enable       in   1             1: start new TX frames / accept RX frames
//  divisor      in   32            bit period = divisor+1 clk cycles
//  tx_avail     in   FIFO_BITS+1   bytes held in host-to-ext FIFO
//  tx_data      in   DATA_WIDTH    head byte of host-to-ext FIFO, valid while tx_avail!=0
//  tx_pop       out  1             1-cycle pop strobe to host-to-ext FIFO
//  rx_data      out  DATA_WIDTH    byte to ext-to-host FIFO
//  rx_push      out  1             1-cycle push strobe, rx_data valid same cycle
//  rx_full      in   1             ext-to-host FIFO cannot accept
//  ser_o        out  1             serial out, idles high
//  ser_i        in   1             serial in (async), idles high
//  tx_busy      out  1             TX frame in progress
//  rx_overrun   out  1             sticky: frame dropped because rx_full
//  rx_frame_err out  1             sticky: stop bit sampled low
//  err_clr      in   1             clears both sticky flags (set wins if same cycle)
// BEHAVIOUR
//  Reset (rstn=0 at posedge): ser_o=1, tx_pop=0, rx_push=0, rx_data=0, tx_busy=0, both sticky
//   flags=0, both FSMs IDLE, synchronizer=2'b11. Reset mid-frame aborts the frame; no pop/push.
//  Bit timer: down-counter reloaded with divisor at each bit boundary; tick when count==0.
//   divisor latched at frame start; changes mid-frame take effect next frame.
//  TX FSM IDLE->START->DATA->STOP->IDLE:
//   IDLE: if enable && tx_avail!=0: tx_pop=1 for exactly that cycle, latch tx_data, ->START.
//   START: ser_o=0 for divisor+1 cycles. DATA: bit i driven for divisor+1 cycles, i=0..7.
//   STOP: ser_o=1 for divisor+1 cycles, then IDLE; back-to-back frames when FIFO non-empty
//   (IDLE lasts exactly 1 cycle between frames). ser_o registered.
//   enable falling mid-frame: frame completes; no further pops.
//   tx_busy=1 in START/DATA/STOP.
//  RX: ser_i through 2-flop synchronizer (2-cycle latency); FSM IDLE->START->DATA->STOP->IDLE.
//   IDLE: synchronized falling level (0) with enable=1 -> START, counter=divisor>>1.
//   START: at tick resample; 1 -> IDLE (glitch, no flag), 0 -> DATA, counter=divisor.
//   DATA: sample at each tick (mid-bit), shift in LSB-first, 8 samples -> STOP.
//   STOP: at tick: sample 0 -> rx_frame_err=1, no push; sample 1 && !rx_full -> rx_push=1,
//   rx_data=byte; sample 1 && rx_full -> rx_overrun=1, no push. Then IDLE.
//   enable falling mid-frame: frame completes normally.
//  TX and RX independent; full-duplex simultaneous operation required.
// STRUCTURE
//  fpio_pkg: FPIO_DATA_WIDTH=8 constant, typedef enum {IDLE,START,DATA,STOP} fpio_ser_state_e.
//  Sub-module fpio_bit_timer (load, reload value, tick out); one instance each for TX and RX.
// TESTING
//  divisor=3, tx_avail=1, tx_data=8'hA5 -> one tx_pop; ser_o 0,1,0,1,0,0,1,0,1,1 each 4 clk.
//  divisor=0, 3 bytes queued -> 3 pops, 30 clk of frames + 1 IDLE cycle between frames.
//  Loop ser_o->ser_i, divisor=7, send 8'h3C -> rx_push once, rx_data=8'h3C, no flags.
//  RX frame 8'h55 with stop bit 0 -> rx_frame_err=1, no push; err_clr -> flag 0.
//  rx_full=1, valid frame 8'hFF -> rx_overrun=1, no push; 1-clk low glitch on ser_i -> no frame.
//  rstn=0 during TX DATA bit 3 -> next cycle ser_o=1, tx_busy=0; no extra tx_pop after reset.

Source files
------------

// File: rtl/fpio_pkg.sv
// Shared types and constants for the fpio serial link.
// Both the TX and RX sequencers use the same four-phase frame state encoding.
package fpio_pkg;

    localparam int FPIO_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } fpio_ser_state_e;

endpackage

// File: rtl/fpio_serial_ctrl_if.sv
// Byte-FIFO side of the serial controller: host-to-ext read port and ext-to-host write port.
// master is the controller (issues pop/push), slave is the FIFO pair.
interface fpio_serial_ctrl_if
    import fpio_pkg::*;
#(
    parameter int FIFO_BITS  = 8,
    parameter int DATA_WIDTH = FPIO_DATA_WIDTH
) ();

    logic [FIFO_BITS:0]    tx_avail;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_pop;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_push;
    logic                  rx_full;

    modport master (
        input  tx_avail, tx_data, rx_full,
        output tx_pop, rx_data, rx_push
    );

    modport slave (
        output tx_avail, tx_data, rx_full,
        input  tx_pop, rx_data, rx_push
    );

endinterface

// File: rtl/fpio_bit_timer.sv
// Bit-period down-counter: load restarts it at reload, tick is high while the count is zero.
// Tick period is reload+1 cycles when reloaded on every tick; no backpressure.
module fpio_bit_timer (
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic [31:0] reload,
    output logic        tick
);

    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = reload;
        end else if (cnt_q != 32'd0) begin
            cnt_d = cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == 32'd0);

endmodule

// File: rtl/fpio_serial_ctrl.sv
// Frames FIFO bytes onto ser_o (start, LSB-first data, stop) and deframes ser_i into FIFO pushes.
// TX pops only when idle and enabled; a full RX FIFO drops the frame and raises rx_overrun.
module fpio_serial_ctrl
    import fpio_pkg::*;
#(
    parameter int FIFO_BITS  = 8,
    parameter int DATA_WIDTH = FPIO_DATA_WIDTH
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                enable,
    input  logic [31:0]         divisor,
    fpio_serial_ctrl_if.master  fifo,
    output logic                ser_o,
    input  logic                ser_i,
    output logic                tx_busy,
    output logic                rx_overrun,
    output logic                rx_frame_err,
    input  logic                err_clr
);

    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    fpio_ser_state_e       tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [BIT_W-1:0]      tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [31:0]           tx_div_q, tx_div_d, rx_div_q, rx_div_d, tx_reload, rx_reload;
    logic                  ser_o_q, ser_o_d, rx_push_q, rx_push_d;
    logic                  ovr_q, ovr_d, ferr_q, ferr_d;
    logic [1:0]            sync_q, sync_d;
    logic                  tx_load, tx_tick, rx_load, rx_tick, tx_pop, rx_in;
    logic                  ovr_set, ferr_set;

    fpio_bit_timer u_tx_timer (.clk(clk), .rstn(rstn), .load(tx_load), .reload(tx_reload), .tick(tx_tick));
    fpio_bit_timer u_rx_timer (.clk(clk), .rstn(rstn), .load(rx_load), .reload(rx_reload), .tick(rx_tick));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_div_d   = tx_div_q;
        ser_o_d    = ser_o_q;
        tx_pop     = 1'b0;
        tx_load    = 1'b0;
        tx_reload  = tx_div_q;
        unique case (tx_state_q)
            IDLE: begin
                ser_o_d = 1'b1;
                if (rstn && enable && fifo.tx_avail != (FIFO_BITS + 1)'(0)) begin
                    // divisor is captured here so mid-frame changes only affect the next frame
                    tx_pop     = 1'b1;
                    tx_sh_d    = fifo.tx_data;
                    tx_div_d   = divisor;
                    tx_reload  = divisor;
                    tx_load    = 1'b1;
                    tx_bit_d   = '0;
                    ser_o_d    = 1'b0;
                    tx_state_d = START;
                end
            end
            START: if (tx_tick) begin
                tx_load    = 1'b1;
                ser_o_d    = tx_sh_q[0];
                tx_sh_d    = tx_sh_q >> 1;
                tx_state_d = DATA;
            end
            DATA: if (tx_tick) begin
                tx_load = 1'b1;
                if (tx_bit_q == LAST_BIT) begin
                    ser_o_d    = 1'b1;
                    tx_state_d = STOP;
                end else begin
                    ser_o_d  = tx_sh_q[0];
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_bit_d = tx_bit_q + 1'b1;
                end
            end
            STOP: if (tx_tick) begin
                tx_state_d = IDLE;
            end
            default: tx_state_d = IDLE;
        endcase
    end

    assign sync_d = {sync_q[0], ser_i};
    assign rx_in  = sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_sh_d    = rx_sh_q;
        rx_bit_d   = rx_bit_q;
        rx_div_d   = rx_div_q;
        rx_data_d  = rx_data_q;
        rx_push_d  = 1'b0;
        rx_load    = 1'b0;
        rx_reload  = rx_div_q;
        ovr_set    = 1'b0;
        ferr_set   = 1'b0;
        unique case (rx_state_q)
            IDLE: if (enable && !rx_in) begin
                // half a bit period lands every later sample mid-bit
                rx_div_d   = divisor;
                rx_reload  = divisor >> 1;
                rx_load    = 1'b1;
                rx_bit_d   = '0;
                rx_state_d = START;
            end
            START: if (rx_tick) begin
                if (rx_in) begin
                    rx_state_d = IDLE;
                end else begin
                    rx_load    = 1'b1;
                    rx_state_d = DATA;
                end
            end
            DATA: if (rx_tick) begin
                rx_load = 1'b1;
                rx_sh_d = {rx_in, rx_sh_q[DATA_WIDTH-1:1]};
                if (rx_bit_q == LAST_BIT) begin
                    rx_state_d = STOP;
                end else begin
                    rx_bit_d = rx_bit_q + 1'b1;
                end
            end
            STOP: if (rx_tick) begin
                rx_state_d = IDLE;
                if (!rx_in) begin
                    ferr_set = 1'b1;
                end else if (fifo.rx_full) begin
                    ovr_set = 1'b1;
                end else begin
                    rx_push_d = 1'b1;
                    rx_data_d = rx_sh_q;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    assign ovr_d  = ovr_set | (ovr_q & ~err_clr);
    assign ferr_d = ferr_set | (ferr_q & ~err_clr);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tx_state_q <= IDLE;
            rx_state_q <= IDLE;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            tx_bit_q   <= '0;
            rx_bit_q   <= '0;
            tx_div_q   <= '0;
            rx_div_q   <= '0;
            rx_data_q  <= '0;
            ser_o_q    <= 1'b1;
            rx_push_q  <= 1'b0;
            ovr_q      <= 1'b0;
            ferr_q     <= 1'b0;
            sync_q     <= 2'b11;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            tx_bit_q   <= tx_bit_d;
            rx_bit_q   <= rx_bit_d;
            tx_div_q   <= tx_div_d;
            rx_div_q   <= rx_div_d;
            rx_data_q  <= rx_data_d;
            ser_o_q    <= ser_o_d;
            rx_push_q  <= rx_push_d;
            ovr_q      <= ovr_d;
            ferr_q     <= ferr_d;
            sync_q     <= sync_d;
        end
    end

    assign fifo.tx_pop  = tx_pop;
    assign fifo.rx_push = rx_push_q;
    assign fifo.rx_data = rx_data_q;
    assign ser_o        = ser_o_q;
    assign tx_busy      = (tx_state_q != IDLE);
    assign rx_overrun   = ovr_q;
    assign rx_frame_err = ferr_q;

endmodule

// File: tb/tb_fpio_serial_ctrl.sv
// Directed bench for fpio_serial_ctrl: TX framing, back-to-back pops, loopback, RX error paths, reset abort.
module tb_fpio_serial_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [31:0] divisor;
    logic        ser_o, ser_drv, loop_en, tx_busy, rx_overrun, rx_frame_err, err_clr;
    wire         ser_i_w = loop_en ? ser_o : ser_drv;

    int total = 0;
    int bad   = 0;
    int pop_cnt  = 0;
    int push_cnt = 0;
    logic [7:0] last_rx = 8'h00;

    fpio_serial_ctrl_if #(.FIFO_BITS(8), .DATA_WIDTH(8)) fif ();

    fpio_serial_ctrl #(.FIFO_BITS(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .divisor(divisor), .fifo(fif),
        .ser_o(ser_o), .ser_i(ser_i_w), .tx_busy(tx_busy), .rx_overrun(rx_overrun),
        .rx_frame_err(rx_frame_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fif.tx_pop === 1'b1) pop_cnt++;
        if (fif.rx_push === 1'b1) begin
            push_cnt++;
            last_rx = fif.rx_data;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ser_drv = fr[i];
            repeat (4) @(posedge clk);
            #1;
        end
        ser_drv = 1'b1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; enable = 1'b0; divisor = 32'd3; fif.tx_avail = '0; fif.tx_data = '0;
        fif.rx_full = 1'b0; ser_drv = 1'b1; loop_en = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (ser_o !== 1'b1) begin bad++; $display("FAIL reset_ser_o got=%b exp=1", ser_o); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_tx_busy got=%b exp=0", tx_busy); end
        total++; if (fif.tx_pop !== 1'b0) begin bad++; $display("FAIL reset_tx_pop got=%b exp=0", fif.tx_pop); end
        total++; if (fif.rx_push !== 1'b0) begin bad++; $display("FAIL reset_rx_push got=%b exp=0", fif.rx_push); end
        total++; if (fif.rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", fif.rx_data); end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", rx_overrun); end
        total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", rx_frame_err); end
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    task automatic test_tx_frame;
        logic [9:0] fr;
        int p0;
        fr = {1'b1, 8'hA5, 1'b0};
        @(posedge clk); #1;
        p0 = pop_cnt; divisor = 32'd3; fif.tx_data = 8'hA5; fif.tx_avail = 9'd1; enable = 1'b1;
        @(negedge clk);
        total++; if (fif.tx_pop !== 1'b1) begin bad++; $display("FAIL tx_pop_strobe got=%b exp=1", fif.tx_pop); end
        @(posedge clk); #1 fif.tx_avail = '0; fif.tx_data = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            total++;
            if (ser_o !== fr[i/4]) begin bad++; $display("FAIL tx_a5_bit cyc=%0d got=%b exp=%b", i, ser_o, fr[i/4]); end
            if (i == 20) begin
                total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL tx_busy_mid got=%b exp=1", tx_busy); end
            end
        end
        @(negedge clk);
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL tx_busy_end got=%b exp=0", tx_busy); end
        total++; if (ser_o !== 1'b1) begin bad++; $display("FAIL tx_idle_ser got=%b exp=1", ser_o); end
        @(posedge clk); #1;
        total++; if (pop_cnt - p0 != 1) begin bad++; $display("FAIL tx_pop_count got=%0d exp=1", pop_cnt - p0); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [3];
        logic exp_ser, exp_pop, pop_seen;
        int idx, rel, f, k;
        bytes = '{8'h01, 8'h80, 8'hC3};
        @(posedge clk); #1;
        divisor = 32'd0; idx = 0; fif.tx_data = bytes[0]; fif.tx_avail = 9'd3;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            rel = c % 11; f = c / 11; k = rel - 1;
            exp_pop = (c == 0 || c == 11 || c == 22);
            if (rel == 0 || f >= 3 || k == 9) exp_ser = 1'b1;
            else if (k == 0) exp_ser = 1'b0;
            else exp_ser = bytes[f][k-1];
            total++; if (fif.tx_pop !== exp_pop) begin bad++; $display("FAIL b2b_pop cyc=%0d got=%b exp=%b", c, fif.tx_pop, exp_pop); end
            total++; if (ser_o !== exp_ser) begin bad++; $display("FAIL b2b_ser cyc=%0d got=%b exp=%b", c, ser_o, exp_ser); end
            pop_seen = fif.tx_pop;
            @(posedge clk); #1;
            if (pop_seen === 1'b1) begin
                idx++;
                fif.tx_avail = 9'(3 - idx);
                fif.tx_data = (idx < 3) ? bytes[idx] : 8'h00;
            end
        end
    endtask

    task automatic test_loopback;
        int p0, q0;
        @(posedge clk); #1;
        p0 = push_cnt; q0 = pop_cnt; loop_en = 1'b1; divisor = 32'd7;
        fif.tx_data = 8'h3C; fif.tx_avail = 9'd1; fif.rx_full = 1'b0;
        @(posedge clk); #1 fif.tx_avail = '0;
        for (int c = 0; c < 200 && push_cnt == p0; c++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        total++; if (push_cnt - p0 != 1) begin bad++; $display("FAIL loop_push_count got=%0d exp=1", push_cnt - p0); end
        total++; if (last_rx !== 8'h3C) begin bad++; $display("FAIL loop_rx_data got=%h exp=3c", last_rx); end
        total++; if ({rx_overrun, rx_frame_err} !== 2'b00) begin bad++; $display("FAIL loop_flags got=%b exp=00", {rx_overrun, rx_frame_err}); end
        total++; if (pop_cnt - q0 != 1) begin bad++; $display("FAIL loop_pop_count got=%0d exp=1", pop_cnt - q0); end
        loop_en = 1'b0; ser_drv = 1'b1; divisor = 32'd3;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_rx_direct;
        int p0;
        p0 = push_cnt;
        send_frame(8'h96, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        total++; if (push_cnt - p0 != 1) begin bad++; $display("FAIL rx96_push_count got=%0d exp=1", push_cnt - p0); end
        total++; if (last_rx !== 8'h96) begin bad++; $display("FAIL rx96_data got=%h exp=96", last_rx); end
    endtask

    task automatic test_frame_err;
        int p0;
        p0 = push_cnt;
        send_frame(8'h55, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        total++; if (rx_frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set got=%b exp=1", rx_frame_err); end
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL ferr_ovr got=%b exp=0", rx_overrun); end
        total++; if (push_cnt - p0 != 0) begin bad++; $display("FAIL ferr_push got=%0d exp=0", push_cnt - p0); end
        err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b exp=0", rx_frame_err); end
    endtask

    task automatic test_overrun;
        int p0;
        p0 = push_cnt; fif.rx_full = 1'b1;
        send_frame(8'hFF, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        total++; if (rx_overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", rx_overrun); end
        total++; if (rx_frame_err !== 1'b0) begin bad++; $display("FAIL ovr_ferr got=%b exp=0", rx_frame_err); end
        total++; if (push_cnt - p0 != 0) begin bad++; $display("FAIL ovr_push got=%0d exp=0", push_cnt - p0); end
        err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0; fif.rx_full = 1'b0;
        total++; if (rx_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", rx_overrun); end
    endtask

    task automatic test_glitch;
        int p0;
        p0 = push_cnt;
        ser_drv = 1'b0;
        @(posedge clk); #1 ser_drv = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        total++; if (push_cnt - p0 != 0) begin bad++; $display("FAIL glitch_push got=%0d exp=0", push_cnt - p0); end
        total++; if ({rx_overrun, rx_frame_err} !== 2'b00) begin bad++; $display("FAIL glitch_flags got=%b exp=00", {rx_overrun, rx_frame_err}); end
    endtask

    task automatic test_reset_mid_tx;
        int p0;
        @(posedge clk); #1;
        p0 = pop_cnt; divisor = 32'd3; fif.tx_data = 8'h00; fif.tx_avail = 9'd1; enable = 1'b1;
        @(posedge clk); #1 fif.tx_avail = '0;
        repeat (18) @(negedge clk);
        total++; if (ser_o !== 1'b0) begin bad++; $display("FAIL rst_mid_bit3 got=%b exp=0", ser_o); end
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL rst_mid_busy got=%b exp=1", tx_busy); end
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        total++; if (ser_o !== 1'b1) begin bad++; $display("FAIL rst_abort_ser got=%b exp=1", ser_o); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rst_abort_busy got=%b exp=0", tx_busy); end
        repeat (30) @(posedge clk);
        #1;
        total++; if (pop_cnt - p0 != 1) begin bad++; $display("FAIL rst_pop_count got=%0d exp=1", pop_cnt - p0); end
        total++; if (ser_o !== 1'b1) begin bad++; $display("FAIL rst_idle_ser got=%b exp=1", ser_o); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_loopback();
        test_rx_direct();
        test_frame_err();
        test_overrun();
        test_glitch();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
